execute_stage: RTL
==================

# execute_stage

Execute stage of the pipelined RV32 core: takes a decoded, operand-ready instruction from decode, computes the ALU result (and, when enabled, an iterative M-extension multiply/divide), and registers the EX/MEM payload consumed directly by the memory stage. It owns the only multi-cycle functional unit in the core and back-pressures decode with a stall while that unit is busy.

## Interface
- ADDRESS_WIDTH, 32, PC width
- DATA_WIDTH, 32, operand/result width; the multiply/divide path is defined for 32 only
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- issue_valid_d  in  1  decode presents a valid instruction this cycle
- src_a_d, src_b_d  in  DATA_WIDTH  operands, already forwarded and immediate-selected
- write_data_d  in  DATA_WIDTH  store data (rs2 value)
- alu_control_d  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 PASS_B; 11-15 give 0
- is_muldiv_d  in  1  instruction is an M-extension op
- muldiv_op_d  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- reg_write_d, mem_write_d  in  1  control bits carried through
- result_src_d  in  2  writeback select carried through
- rd_d  in  5  destination register
- pc_plus4_d  in  ADDRESS_WIDTH  carried through
- flush_e  in  1  cancel the instruction in execute (branch mispredict)
- stall_d  out  1  decode must hold its instruction
- valid_e  out  1  EX/MEM payload is a real instruction
- alu_result_e, write_data_e  out  DATA_WIDTH  registered result / store data
- reg_write_e, mem_write_e  out  1  registered control; forced 0 when valid_e=0
- result_src_e  out  2  registered
- rd_e  out  5  registered
- pc_plus4_e  out  ADDRESS_WIDTH  registered

## Operation
- Reset (rst_n=0 at an edge): every output register 0, valid_e=0, FSM IDLE, stall_d=0.
- FSM states IDLE, BUSY, DONE.
- IDLE, issue_valid_d=1, is_muldiv_d=0: ALU result and all carried fields registered at the edge; valid_e=1 next cycle.
- IDLE, issue_valid_d=0: bubble registered (valid_e=0, reg_write_e=0, mem_write_e=0).
- IDLE, M-op accepted: operands/control latched, counter=0, go BUSY; special cases below bypass BUSY and complete like an ALU op.
- BUSY: one iteration per cycle (shift-add multiply over 64-bit product; restoring divide), counter increments; after iteration 31 go DONE. Output register holds bubbles.
- DONE: result and latched control registered, valid_e=1 next cycle, return IDLE.
- Signed handling: operate on magnitudes, fix sign at DONE. MULH signed×signed, MULHSU signed rs1×unsigned rs2, MULHU unsigned; MUL returns low 32 bits.
- Divide by zero: quotient 0xFFFFFFFF (DIV/DIVU), remainder = dividend, single cycle.
- Signed overflow (0x80000000 / 0xFFFFFFFF): DIV 0x80000000, REM 0, single cycle.
- Shifts use src_b_d[4:0]; SLT/SLTU give 0 or 1.
- flush_e=1: in-flight M-op abandoned, FSM to IDLE, bubble registered; flush has priority over issue in the same cycle.

## Timing
- ALU op: result visible 1 cycle after issue.
- M-op (non-special): issue at edge 0, BUSY edges 1-32, DONE at edge 33; valid_e high in the cycle after edge 33, for exactly one cycle.
- stall_d is combinational: 1 in BUSY and DONE, 0 otherwise; decode presents the next instruction unchanged until stall_d=0.
- Reset mid-BUSY discards the operation; no result is produced.

## Configuration
- MULDIV_EN defined: M-extension datapath and FSM compiled in as above.
- MULDIV_EN undefined: no multiply/divide hardware; an is_muldiv_d instruction completes in one cycle with alu_result_e=0 and reg_write_e=0 (valid_e=1), stall_d tied 0, FSM stays IDLE.

## Test plan
- Reset: hold rst_n=0 two cycles with issue_valid_d=1 -> all outputs 0, valid_e=0, stall_d=0.
- ADD 0x7FFFFFFF+1 then SRA 0x80000000>>4 back-to-back -> 0x80000000 then 0xF8000000 on consecutive cycles, rd/pc_plus4 carried.
- MULH 0xFFFFFFFF×0xFFFFFFFF -> 0x00000000; MULHU same -> 0xFFFFFFFE; each valid 34 cycles after issue, stall_d high cycles 1-33.
- DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF single cycle; DIV 0x80000000/-1 -> 0x80000000 single cycle.
- flush_e at BUSY cycle 10 of DIVU -> no valid_e for it, stall_d drops next cycle, next ALU op completes normally.
- MULDIV_EN undefined: MUL 3×4 -> valid_e=1, reg_write_e=0, alu_result_e=0, stall_d never asserted.

Source files
------------

// File: rtl/execute_stage.sv
// execute_stage -- EX stage of the pipelined RV32 core.
//
// Computes the ALU result for a decoded, operand-ready instruction and
// registers the EX/MEM payload read directly by the memory stage. When the
// MULDIV_EN macro is defined, an iterative M-extension unit (shift-add
// multiply, restoring divide, one bit per cycle) is compiled in and decode is
// stalled while it runs. With MULDIV_EN undefined an M-op retires in one cycle
// as a harmless no-write instruction.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   issue_valid_d              decode presents an instruction
//   src_a_d, src_b_d           forwarded / immediate-selected operands
//   write_data_d               store data
//   alu_control_d              ALU op select (ADD..PASS_B, 11-15 give 0)
//   is_muldiv_d, muldiv_op_d   M-extension op flag and funct3
//   reg_write_d, mem_write_d,
//   result_src_d, rd_d,
//   pc_plus4_d                 control / carried fields
//   flush_e                    cancel the instruction in execute
//   stall_d                    decode must hold its instruction
//   valid_e ... pc_plus4_e     registered EX/MEM payload
module execute_stage #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid_d,
  input  logic [DATA_WIDTH-1:0]    src_a_d,
  input  logic [DATA_WIDTH-1:0]    src_b_d,
  input  logic [DATA_WIDTH-1:0]    write_data_d,
  input  logic [3:0]               alu_control_d,
  input  logic                     is_muldiv_d,
  input  logic [2:0]               muldiv_op_d,
  input  logic                     reg_write_d,
  input  logic                     mem_write_d,
  input  logic [1:0]               result_src_d,
  input  logic [4:0]               rd_d,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
  input  logic                     flush_e,
  output logic                     stall_d,
  output logic                     valid_e,
  output logic [DATA_WIDTH-1:0]    alu_result_e,
  output logic [DATA_WIDTH-1:0]    write_data_e,
  output logic                     reg_write_e,
  output logic                     mem_write_e,
  output logic [1:0]               result_src_e,
  output logic [4:0]               rd_e,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_e
);

  // ---- stage p0: combinational ALU on decode operands ----
  logic signed [DATA_WIDTH-1:0] src_a_s, src_b_s;
  logic        [DATA_WIDTH-1:0] alu_out_p0;

  assign src_a_s = src_a_d;
  assign src_b_s = src_b_d;

  always_comb begin
    alu_out_p0 = '0;
    case (alu_control_d)
      4'd0:    alu_out_p0 = src_a_d + src_b_d;
      4'd1:    alu_out_p0 = src_a_d - src_b_d;
      4'd2:    alu_out_p0 = src_a_d & src_b_d;
      4'd3:    alu_out_p0 = src_a_d | src_b_d;
      4'd4:    alu_out_p0 = src_a_d ^ src_b_d;
      4'd5:    alu_out_p0 = {{(DATA_WIDTH-1){1'b0}}, (src_a_s < src_b_s)};
      4'd6:    alu_out_p0 = {{(DATA_WIDTH-1){1'b0}}, (src_a_d < src_b_d)};
      4'd7:    alu_out_p0 = src_a_d << src_b_d[4:0];
      4'd8:    alu_out_p0 = src_a_d >> src_b_d[4:0];
      4'd9:    alu_out_p0 = src_a_s >>> src_b_d[4:0];
      4'd10:   alu_out_p0 = src_b_d;
      default: alu_out_p0 = '0;
    endcase
  end

  // Single-cycle result/write-enable and the iterative-unit hand-off.
  logic                     md_start_p0;
  logic                     md_idle;
  logic                     md_done;
  logic [DATA_WIDTH-1:0]    result_p0;
  logic                     reg_write_p0;
  logic [DATA_WIDTH-1:0]    md_result_p1;
  logic [DATA_WIDTH-1:0]    write_data_p1;
  logic                     reg_write_p1;
  logic                     mem_write_p1;
  logic [1:0]               result_src_p1;
  logic [4:0]               rd_p1;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_p1;

`ifdef MULDIV_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [2:0]  op_p1;
  logic        neg_p1;
  logic [31:0] acc_hi, acc_lo, mcand;

  // Two's-complement negate when the result sign must be flipped.
  function automatic logic [63:0] fix_sign64(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

  function automatic logic [31:0] fix_sign32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  logic        a_sgn, b_sgn, a_neg, b_neg, neg_p0;
  logic [31:0] a_mag, b_mag;
  logic        div_zero, div_ovf, special_p0;
  logic [31:0] special_res_p0;

  always_comb begin
    // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM also rs2.
    a_sgn = (muldiv_op_d == 3'd1) || (muldiv_op_d == 3'd2) ||
            (muldiv_op_d == 3'd4) || (muldiv_op_d == 3'd6);
    b_sgn = (muldiv_op_d == 3'd1) || (muldiv_op_d == 3'd4) ||
            (muldiv_op_d == 3'd6);
    a_neg = a_sgn & src_a_d[31];
    b_neg = b_sgn & src_b_d[31];
    a_mag = fix_sign32(src_a_d, a_neg);
    b_mag = fix_sign32(src_b_d, b_neg);
    // Remainder takes the dividend's sign; everything else the XOR.
    neg_p0 = (muldiv_op_d == 3'd6) ? a_neg : (a_neg ^ b_neg);

    div_zero = muldiv_op_d[2] && (src_b_d == 32'd0);
    div_ovf  = muldiv_op_d[2] && !muldiv_op_d[0] &&
               (src_a_d == 32'h8000_0000) && (src_b_d == 32'hFFFF_FFFF);
    special_p0 = div_zero || div_ovf;
    special_res_p0 = '0;
    if (div_zero)
      special_res_p0 = muldiv_op_d[1] ? src_a_d : 32'hFFFF_FFFF;
    else if (div_ovf)
      special_res_p0 = muldiv_op_d[1] ? 32'd0 : 32'h8000_0000;
  end

  assign md_idle     = (state == IDLE);
  assign md_done     = (state == DONE);
  assign md_start_p0 = md_idle && issue_valid_d && !flush_e && is_muldiv_d && !special_p0;
  assign result_p0   = is_muldiv_d ? special_res_p0 : alu_out_p0;
  assign reg_write_p0 = reg_write_d;
  assign stall_d     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (md_start_p0) state_nxt = BUSY;
      BUSY:    if (cnt == 5'd31) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush_e) state_nxt = IDLE;
  end

  // ---- stage p1: iterative multiply / divide ----
  logic [32:0] mul_sum, div_shift;
  logic        div_ge;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : 33'd0);
    div_shift = {acc_hi, acc_lo[31]};
    div_ge    = (div_shift >= {1'b0, mcand});
  end

  always_ff @(posedge clk) begin
    if (md_start_p0) begin
      op_p1         <= muldiv_op_d;
      neg_p1        <= neg_p0;
      acc_hi        <= '0;
      acc_lo        <= a_mag;
      mcand         <= b_mag;
      cnt           <= '0;
      write_data_p1 <= write_data_d;
      reg_write_p1  <= reg_write_d;
      mem_write_p1  <= mem_write_d;
      result_src_p1 <= result_src_d;
      rd_p1         <= rd_d;
      pc_plus4_p1   <= pc_plus4_d;
    end else if (state == BUSY) begin
      cnt <= cnt + 5'd1;
      if (!op_p1[2]) begin
        // Shift-add: product accumulates in {acc_hi, acc_lo}.
        acc_hi <= mul_sum[32:1];
        acc_lo <= {mul_sum[0], acc_lo[31:1]};
      end else if (div_ge) begin
        // Restoring divide: remainder in acc_hi, quotient shifts into acc_lo.
        acc_hi <= 32'(div_shift - {1'b0, mcand});
        acc_lo <= {acc_lo[30:0], 1'b1};
      end else begin
        acc_hi <= div_shift[31:0];
        acc_lo <= {acc_lo[30:0], 1'b0};
      end
    end
  end

  logic [63:0] prod_fix;
  logic [31:0] div_fix;

  always_comb begin
    prod_fix = fix_sign64({acc_hi, acc_lo}, neg_p1);
    div_fix  = fix_sign32(op_p1[1] ? acc_hi : acc_lo, neg_p1);
    if (op_p1[2])               md_result_p1 = div_fix;
    else if (op_p1[1:0] == 2'd0) md_result_p1 = prod_fix[31:0];
    else                        md_result_p1 = prod_fix[63:32];
  end
`else
  logic unused_muldiv;

  assign unused_muldiv = ^muldiv_op_d;
  assign md_idle       = 1'b1;
  assign md_done       = 1'b0;
  assign md_start_p0   = 1'b0;
  assign stall_d       = 1'b0;
  // Without the M unit an M-op retires as a no-write instruction.
  assign result_p0     = is_muldiv_d ? '0 : alu_out_p0;
  assign reg_write_p0  = is_muldiv_d ? 1'b0 : reg_write_d;
  assign md_result_p1  = '0;
  assign write_data_p1 = '0;
  assign reg_write_p1  = 1'b0;
  assign mem_write_p1  = 1'b0;
  assign result_src_p1 = '0;
  assign rd_p1         = '0;
  assign pc_plus4_p1   = '0;
`endif

  // ---- EX/MEM register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_e      <= 1'b0;
      alu_result_e <= '0;
      write_data_e <= '0;
      reg_write_e  <= 1'b0;
      mem_write_e  <= 1'b0;
      result_src_e <= '0;
      rd_e         <= '0;
      pc_plus4_e   <= '0;
    end else if (flush_e) begin
      valid_e     <= 1'b0;
      reg_write_e <= 1'b0;
      mem_write_e <= 1'b0;
    end else if (md_done) begin
      valid_e      <= 1'b1;
      alu_result_e <= md_result_p1;
      write_data_e <= write_data_p1;
      reg_write_e  <= reg_write_p1;
      mem_write_e  <= mem_write_p1;
      result_src_e <= result_src_p1;
      rd_e         <= rd_p1;
      pc_plus4_e   <= pc_plus4_p1;
    end else if (md_idle && issue_valid_d && !md_start_p0) begin
      valid_e      <= 1'b1;
      alu_result_e <= result_p0;
      write_data_e <= write_data_d;
      reg_write_e  <= reg_write_p0;
      mem_write_e  <= mem_write_d;
      result_src_e <= result_src_d;
      rd_e         <= rd_d;
      pc_plus4_e   <= pc_plus4_d;
    end else begin
      valid_e     <= 1'b0;
      reg_write_e <= 1'b0;
      mem_write_e <= 1'b0;
    end
  end

endmodule
